// File: rtl/branch_resolution_queue.sv
// Branch resolution queue: holds in-flight predicted conditional branches
// between decode and EX, returns predictor training feedback one cycle after
// each in-order resolve and raises a one-cycle fetch redirect on a misprediction.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   i_alloc_*  / o_alloc_ready     enqueue from decode (pc, prediction, recovery target)
//   i_res_valid, i_res_outcome     EX resolves the oldest outstanding branch
//   i_flush                        external flush, discards every entry
//   o_fb_*                         registered training feedback (valid pulse, data held)
//   o_redirect_valid/_target       registered one-cycle redirect on mispredict
//   o_count, o_mispredict_count    occupancy, saturating mispredict counter
//   o_error                        sticky: a resolve arrived while the queue was empty

package mips_core_pkg;
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;
endpackage

module branch_resolution_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_alloc_valid,
  input  logic [ADDR_WIDTH-1:0]  i_alloc_pc,
  input  logic                   i_alloc_prediction,
  input  logic [ADDR_WIDTH-1:0]  i_alloc_recovery_target,
  output logic                   o_alloc_ready,
  input  logic                   i_res_valid,
  input  logic                   i_res_outcome,
  input  logic                   i_flush,
  output logic                   o_fb_valid,
  output logic [ADDR_WIDTH-1:0]  o_fb_pc,
  output logic                   o_fb_prediction,
  output logic                   o_fb_outcome,
  output logic                   o_redirect_valid,
  output logic [ADDR_WIDTH-1:0]  o_redirect_target,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [15:0]            o_mispredict_count,
  output logic                   o_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry storage; never read while empty, so it carries no reset.
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic                  pred_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rt_mem   [DEPTH];

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  fb_valid_q, fb_valid_d;
  logic [ADDR_WIDTH-1:0] fb_pc_q, fb_pc_d;
  logic                  fb_pred_q, fb_pred_d;
  logic                  fb_out_q, fb_out_d;
  logic                  redir_valid_q, redir_valid_d;
  logic [ADDR_WIDTH-1:0] redir_tgt_q, redir_tgt_d;
  logic [15:0]           mcnt_q, mcnt_d;
  logic                  err_q, err_d;

  logic                  alloc_ready;
  logic                  pop;
  logic                  mispredict_now;
  logic                  push;

  // Readiness comes from the registered count only: a slot freed by a
  // same-cycle pop is not offered to a same-cycle push.
  assign alloc_ready    = (count_q != FULL_CNT);
  assign pop            = i_res_valid & (count_q != '0) & ~i_flush;
  assign mispredict_now = pop & (i_res_outcome != pred_mem[head_q]);
  // A mispredict squashes everything younger, including this cycle's alloc.
  assign push           = i_alloc_valid & alloc_ready & ~i_flush & ~mispredict_now;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fb_valid_d    = 1'b0;
    fb_pc_d       = fb_pc_q;
    fb_pred_d     = fb_pred_q;
    fb_out_d      = fb_out_q;
    redir_valid_d = 1'b0;
    redir_tgt_d   = redir_tgt_q;
    mcnt_d        = mcnt_q;
    err_d         = err_q | (i_res_valid & (count_q == '0));

    if (i_flush) begin
      // Flush wins over push and pop: empty the queue in place.
      count_d = '0;
      tail_d  = head_q;
    end else if (mispredict_now) begin
      // Retire the mispredicted branch and drop every younger entry.
      head_d  = head_q + PW'(1);
      tail_d  = head_q + PW'(1);
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (pop) begin
      fb_valid_d = 1'b1;
      fb_pc_d    = pc_mem[head_q];
      fb_pred_d  = pred_mem[head_q];
      fb_out_d   = i_res_outcome;
    end

    if (mispredict_now) begin
      redir_valid_d = 1'b1;
      redir_tgt_d   = rt_mem[head_q];
      if (mcnt_q != 16'hFFFF) mcnt_d = mcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= i_alloc_pc;
      pred_mem[tail_q] <= i_alloc_prediction;
      rt_mem[tail_q]   <= i_alloc_recovery_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fb_valid_q    <= 1'b0;
      fb_pc_q       <= '0;
      fb_pred_q     <= mips_core_pkg::NOT_TAKEN;
      fb_out_q      <= mips_core_pkg::NOT_TAKEN;
      redir_valid_q <= 1'b0;
      redir_tgt_q   <= '0;
      mcnt_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fb_valid_q    <= fb_valid_d;
      fb_pc_q       <= fb_pc_d;
      fb_pred_q     <= fb_pred_d;
      fb_out_q      <= fb_out_d;
      redir_valid_q <= redir_valid_d;
      redir_tgt_q   <= redir_tgt_d;
      mcnt_q        <= mcnt_d;
      err_q         <= err_d;
    end
  end

  assign o_alloc_ready      = alloc_ready;
  assign o_fb_valid         = fb_valid_q;
  assign o_fb_pc            = fb_pc_q;
  assign o_fb_prediction    = fb_pred_q;
  assign o_fb_outcome       = fb_out_q;
  assign o_redirect_valid   = redir_valid_q;
  assign o_redirect_target  = redir_tgt_q;
  assign o_count            = count_q;
  assign o_mispredict_count = mcnt_q;
  assign o_error            = err_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Bench for branch_resolution_queue: directed scenarios then random traffic,
// each cycle's expected outputs come from a queue-based model and are checked
// by a separate monitor on the falling edge.
module tb_branch_resolution_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_alloc_valid;
  logic [AW-1:0] i_alloc_pc;
  logic          i_alloc_prediction;
  logic [AW-1:0] i_alloc_recovery_target;
  logic          o_alloc_ready;
  logic          i_res_valid;
  logic          i_res_outcome;
  logic          i_flush;
  logic          o_fb_valid;
  logic [AW-1:0] o_fb_pc;
  logic          o_fb_prediction;
  logic          o_fb_outcome;
  logic          o_redirect_valid;
  logic [AW-1:0] o_redirect_target;
  logic [2:0]    o_count;
  logic [15:0]   o_mispredict_count;
  logic          o_error;

  branch_resolution_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_alloc_valid           (i_alloc_valid),
    .i_alloc_pc              (i_alloc_pc),
    .i_alloc_prediction      (i_alloc_prediction),
    .i_alloc_recovery_target (i_alloc_recovery_target),
    .o_alloc_ready           (o_alloc_ready),
    .i_res_valid             (i_res_valid),
    .i_res_outcome           (i_res_outcome),
    .i_flush                 (i_flush),
    .o_fb_valid              (o_fb_valid),
    .o_fb_pc                 (o_fb_pc),
    .o_fb_prediction         (o_fb_prediction),
    .o_fb_outcome            (o_fb_outcome),
    .o_redirect_valid        (o_redirect_valid),
    .o_redirect_target       (o_redirect_target),
    .o_count                 (o_count),
    .o_mispredict_count      (o_mispredict_count),
    .o_error                 (o_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] rt;
  } ent_t;

  typedef struct {
    int          stamp;
    logic        rdy;
    int          cnt;
    logic        fbv;
    logic [31:0] fbpc;
    logic        fbp;
    logic        fbo;
    logic        rv;
    logic [31:0] rt;
    int          mc;
    logic        err;
  } exp_t;

  ent_t mq[$];
  exp_t eq[$];

  // Model state that persists across cycles.
  logic [31:0] m_fbpc;
  logic        m_fbp, m_fbo, m_err;
  logic [31:0] m_rt;
  int          m_mc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic step(input logic av, input logic [31:0] pc, input logic pred,
                      input logic [31:0] rt, input logic rv, input logic outc,
                      input logic fl, input logic rn);
    exp_t e;
    ent_t ent;
    bit   full, mis;
    rst_n                   = rn;
    i_alloc_valid           = av;
    i_alloc_pc              = pc;
    i_alloc_prediction      = pred;
    i_alloc_recovery_target = rt;
    i_res_valid             = rv;
    i_res_outcome           = outc;
    i_flush                 = fl;

    e.fbv = 1'b0;
    e.rv  = 1'b0;
    if (!rn) begin
      mq.delete();
      m_fbpc = '0; m_fbp = 1'b0; m_fbo = 1'b0;
      m_rt = '0; m_mc = 0; m_err = 1'b0;
    end else begin
      full = (mq.size() == DEPTH);
      if (rv && mq.size() == 0) m_err = 1'b1;
      if (fl) mq.delete();
      else begin
        mis = 1'b0;
        if (rv && mq.size() > 0) begin
          ent    = mq.pop_front();
          e.fbv  = 1'b1;
          m_fbpc = ent.pc; m_fbp = ent.pred; m_fbo = outc;
          if (outc != ent.pred) begin
            mis  = 1'b1;
            e.rv = 1'b1;
            m_rt = ent.rt;
            mq.delete();
            if (m_mc < 65535) m_mc++;
          end
        end
        if (av && !full && !mis) begin
          ent.pc = pc; ent.pred = pred; ent.rt = rt;
          mq.push_back(ent);
        end
      end
    end
    e.stamp = cyc + 1;
    e.rdy   = (mq.size() != DEPTH);
    e.cnt   = mq.size();
    e.fbpc  = m_fbpc; e.fbp = m_fbp; e.fbo = m_fbo;
    e.rt    = m_rt;   e.mc  = m_mc;  e.err = m_err;
    eq.push_back(e);
    @(posedge clk); #1;
  endtask

  function automatic logic front_pred();
    return (mq.size() > 0) ? mq[0].pred : 1'b0;
  endfunction

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic push(input logic [31:0] pc, input logic pred, input logic [31:0] rt);
    step(1, pc, pred, rt, 0, 0, 0, 1);
  endtask
  task automatic resolve(input logic outc);
    step(0, 0, 0, 0, 1, outc, 0, 1);
  endtask

  // Monitor: compare whatever the DUT presents this cycle to the oldest expectation.
  exp_t me;
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      me = eq.pop_front();
      chk("stamp",        cyc,                   me.stamp);
      chk("alloc_ready",  32'(o_alloc_ready),    32'(me.rdy));
      chk("count",        32'(o_count),          me.cnt);
      chk("fb_valid",     32'(o_fb_valid),       32'(me.fbv));
      chk("fb_pc",        o_fb_pc,               me.fbpc);
      chk("fb_pred",      32'(o_fb_prediction),  32'(me.fbp));
      chk("fb_outcome",   32'(o_fb_outcome),     32'(me.fbo));
      chk("redir_valid",  32'(o_redirect_valid), 32'(me.rv));
      chk("redir_target", o_redirect_target,     me.rt);
      chk("mcount",       32'(o_mispredict_count), me.mc);
      chk("error",        32'(o_error),          32'(me.err));
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0);        // reset
    idle();

    // Correct TAKEN prediction, feedback only.
    push(32'h100, 1, 32'h108);
    resolve(1);
    idle();

    // NOT_TAKEN mispredicted with two younger entries behind it.
    push(32'h200, 0, 32'h240);
    push(32'h300, 1, 32'h304);
    push(32'h400, 1, 32'h404);
    resolve(1);
    idle();

    // Fill, then push a 5th together with a correct resolve.
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(i) * 16, 1, 32'h900 + 32'(i));
    step(1, 32'h5F0, 1, 32'h9F0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) resolve(front_pred());
    idle();

    // Pointer wrap with overlapping push/resolve.
    push(32'h600, 0, 32'h700);
    for (int i = 1; i < 6; i++) step(1, 32'h600 + 32'(i) * 4, 32'(i) & 1, 32'h700, 1, front_pred(), 0, 1);
    resolve(front_pred());
    idle();

    // Flush beats resolve and alloc.
    push(32'hA00, 1, 32'hB00);
    push(32'hA04, 0, 32'hB04);
    step(1, 32'hA08, 1, 32'hB08, 1, 1, 1, 1);
    idle();

    // Resolve while empty, sticky error, then reset clears it.
    resolve(1);
    idle(); idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic av, rv, oc, fl, rn;
      av = ($urandom_range(99) < 60);
      rv = ($urandom_range(99) < 45);
      oc = ($urandom_range(99) < 80) ? front_pred() : ~front_pred();
      fl = ($urandom_range(99) < 3);
      rn = ($urandom_range(199) != 0);
      step(av, $urandom, 1'($urandom), $urandom, rv, oc, fl, rn);
    end
    idle();

    @(negedge clk); #1;
    chk("scoreboard_drained", eq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolution_queue.md
BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

Interface
REQ-001 Parameter: DEPTH, default 4, in-flight conditional-branch entry count, power of two, range 2..16.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 i_alloc_valid  in  1  decode stage has a predicted conditional branch to enqueue.
REQ-006 i_alloc_pc  in  `ADDR_WIDTH  PC of the enqueued branch.
REQ-007 i_alloc_prediction  in  mips_core_pkg::BranchOutcome  prediction issued at decode.
REQ-008 i_alloc_recovery_target  in  `ADDR_WIDTH  fetch address to use if the prediction is wrong.
REQ-009 o_alloc_ready  out  1  queue can accept an entry this cycle.
REQ-010 i_res_valid  in  1  EX resolved the oldest outstanding branch.
REQ-011 i_res_outcome  in  mips_core_pkg::BranchOutcome  actual direction of that branch.
REQ-012 i_flush  in  1  external pipeline flush; discard all entries.
REQ-013 o_fb_valid / o_fb_pc / o_fb_prediction / o_fb_outcome  out  1 / `ADDR_WIDTH / BranchOutcome / BranchOutcome  predictor training feedback.
REQ-014 o_redirect_valid  out  1  misprediction detected; redirect fetch.
REQ-015 o_redirect_target  out  `ADDR_WIDTH  recovery fetch address.
REQ-016 o_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 o_mispredict_count  out  16  saturating misprediction counter.
REQ-018 o_error  out  1  sticky flag; set on resolve while empty.

Function
REQ-019 Storage: circular buffer of DEPTH entries {pc, prediction, recovery_target}; head and tail pointers wrap modulo DEPTH.
REQ-020 o_alloc_ready = (o_count != DEPTH), combinational from registered count only. A same-cycle pop does not free a slot for a same-cycle push.
REQ-021 Push: when i_alloc_valid & o_alloc_ready & ~i_flush & ~mispredict_now, write at tail, tail+1, count+1.
REQ-022 Push while full is dropped with no state change; entries and count are preserved.
REQ-023 Pop: when i_res_valid & count>0 & ~i_flush, read head, head+1, count-1.
REQ-024 mispredict_now = pop & (i_res_outcome != head.prediction).
REQ-025 Feedback latency: exactly 1 cycle. The cycle after a pop, o_fb_valid=1, o_fb_pc=head.pc, o_fb_prediction=head.prediction, o_fb_outcome=i_res_outcome. Otherwise o_fb_valid=0 and the data outputs hold their last value.
REQ-026 Redirect: the cycle after mispredict_now, o_redirect_valid=1 and o_redirect_target=head.recovery_target. The pulse is one cycle wide.
REQ-027 On mispredict_now, discard all younger entries: next state count=0, tail=head+1, head=head+1. A same-cycle alloc is discarded as wrong-path.
REQ-028 Correct prediction with simultaneous push and pop: count unchanged, both pointers advance.
REQ-029 i_flush has priority over push and pop: next count=0, tail=head. The next cycle has no feedback and no redirect.
REQ-030 Resolve while empty: ignored, with no feedback and no redirect; o_error is set and held until reset.
REQ-031 o_mispredict_count increments by 1 on each mispredict_now and saturates at 16'hFFFF.
REQ-032 Out-of-order resolution is unsupported; resolves are strictly oldest-first.

Reset
REQ-033 On rst_n=0 at a clock edge: head=tail=0, count=0, o_alloc_ready=1, o_fb_valid=0, o_fb_pc=0, o_fb_prediction=NOT_TAKEN, o_fb_outcome=NOT_TAKEN, o_redirect_valid=0, o_redirect_target=0, o_mispredict_count=0, o_error=0.
REQ-034 Reset mid-operation discards all entries. No feedback or redirect is emitted in the cycle after reset is released.
REQ-035 Entry storage need not be reset; it is never read while count=0.

Verification
REQ-036 Push pc=0x100 pred=TAKEN rt=0x108; then resolve TAKEN -> next cycle o_fb_valid=1, o_fb_pc=0x100, o_fb_outcome=TAKEN, o_redirect_valid=0, o_count=0.
REQ-037 Push pc=0x200 pred=NOT_TAKEN rt=0x240, push pc=0x300, push pc=0x400; resolve TAKEN -> next cycle o_redirect_valid=1, o_redirect_target=0x240, o_count=0, o_mispredict_count=1.
REQ-038 Fill 4 entries (DEPTH=4) -> o_alloc_ready=0. Push a 5th plus a correct resolve in the same cycle -> o_count=3. The 5th entry is absent; the next resolved pc is the 2nd entry's.
REQ-039 Perform 6 push/resolve pairs with no mispredict so pointers wrap -> feedback pcs appear in push order, o_count returns to 0.
REQ-040 With count=2, assert i_flush together with i_res_valid and i_alloc_valid -> o_count=0 next cycle, o_fb_valid=0, o_redirect_valid=0.
REQ-041 Resolve while empty -> o_error=1 and stays 1; assert rst_n=0 for one cycle -> o_error=0, all outputs at their reset values.
